// File: rtl/imem_boot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_boot_pkg                                                    |
// | Purpose : Shared definitions for the instruction-memory boot loader:       |
// |           default memory geometry and the controller state encoding.      |
// | Ports   : none (package)                                                   |
// | Options : IMEM_BOOT_CKSUM_EN (used by imem_boot_ctrl) enables the trailing |
// |           checksum byte and the CHECK state.                               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package imem_boot_pkg;

  localparam int IMEM_WORDS_DEF = 256;
  localparam int ADDR_W_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } boot_state_e;

endpackage : imem_boot_pkg
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_byte_packer                                                 |
// | Purpose : Little-endian byte-to-word assembly for the boot loader.         |
// |           Each accepted byte enters at the top of a shift register so      |
// |           that after four bytes lane 0 sits in [7:0] and lane 3 in [31:24].|
// | Ports   : clk, rst       clock / async active-high reset                   |
// |           clr            restart assembly at lane 0                        |
// |           shift          a byte is accepted this cycle                     |
// |           byte_in[7:0]   the byte being accepted                           |
// |           lane_last      current lane is 3 (this byte completes a word)    |
// |           word_next[31:0] word as it stands including byte_in             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic        lane_last,
  output logic [31:0] word_next
);

  // Only three bytes ever need storing: the fourth is consumed directly from
  // byte_in in the same cycle the completed word is captured by the parent.
  logic [23:0] sr_q, sr_d;
  logic [1:0]  lane_q, lane_d;

  assign word_next = {byte_in, sr_q};
  assign lane_last = (lane_q == 2'd3);

  always_comb begin
    sr_d   = sr_q;
    lane_d = lane_q;
    if (clr) begin
      sr_d   = '0;
      lane_d = 2'd0;
    end else if (shift) begin
      sr_d   = word_next[31:8];
      lane_d = lane_q + 2'd1;   // natural 2-bit wrap 3 -> 0
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      lane_q <= 2'd0;
    end else begin
      sr_q   <= sr_d;
      lane_q <= lane_d;
    end
  end

endmodule : imem_byte_packer
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_boot_ctrl                                                   |
// | Purpose : Loads a program into instruction memory from a byte stream      |
// |           while holding the core in reset. Bytes are packed little-endian |
// |           into 32-bit words and written to consecutive word addresses.    |
// | Ports   : clk, rst          clock / async active-high reset               |
// |           start, word_count load request and word count (clamped)         |
// |           byte_valid/_data  loader byte stream, byte_ready handshake      |
// |           imem_we/_waddr/_wdata  instruction-memory write port            |
// |           core_rst, busy, done, err  status to the rest of the SoC        |
// | Options : IMEM_BOOT_CKSUM_EN -- when defined, a trailing checksum byte     |
// |           (mod-256 sum of all data bytes) is accepted in CHECK and err    |
// |           is set on mismatch. Undefined: no CHECK state, err tied to 0.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(IMEM_WORDS);

  boot_state_e       state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   start_count;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              xfer;
  logic              last_word;
  logic              pk_clr, pk_shift, pk_last;
  logic [31:0]       pk_word;

  // Counts beyond the memory depth are clamped, so the index can never
  // address past IMEM_WORDS-1.
  assign start_count = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
  assign idx_inc     = idx_q + (ADDR_W+1)'(1);
  assign last_word   = (idx_inc == count_q);
  assign xfer        = byte_valid & byte_ready;

  imem_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .shift     (pk_shift),
    .byte_in   (byte_data),
    .lane_last (pk_last),
    .word_next (pk_word)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (start_count == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (xfer && pk_last) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (last_word) begin
`ifdef IMEM_BOOT_CKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_BOOT_CKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    byte_ready = (state_q == ST_RECV);
`ifdef IMEM_BOOT_CKSUM_EN
    byte_ready = byte_ready | (state_q == ST_CHECK);
`endif
    imem_we    = (state_q == ST_WRITE);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    // The core stays in reset both while loading and while rst itself is high.
    core_rst   = rst | (state_q != ST_IDLE);
    imem_waddr = waddr_q;
    imem_wdata = wdata_q;
  end

  // ------------------------------------------------------------- datapath
  always_comb begin
    count_d  = count_q;
    idx_d    = idx_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = start_count;
          idx_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      ST_RECV: begin
        if (xfer) begin
          pk_shift = 1'b1;
          // Capture address and word on the completing byte so they are
          // already stable during the single WRITE cycle, and then hold.
          if (pk_last) begin
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = pk_word;
          end
        end
      end
      ST_WRITE: idx_d = idx_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // ------------------------------------------------------------- checksum
`ifdef IMEM_BOOT_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;

  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (state_q == ST_IDLE && start) begin
      sum_d = '0;
      err_d = 1'b0;
    end else if (state_q == ST_RECV && xfer) begin
      sum_d = sum_q + byte_data;
    end else if (state_q == ST_CHECK && xfer) begin
      err_d = (byte_data != sum_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : imem_boot_ctrl
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_imem_boot_ctrl                                                |
// | Purpose : Self-checking bench for imem_boot_ctrl. A transaction-level      |
// |           model (byte/word counters) predicts every output each cycle;    |
// |           directed loads pin the model with literal expectations, then    |
// |           randomized traffic exercises starts, gaps and resets.           |
// | Options : IMEM_BOOT_CKSUM_EN selects the checksum-enabled expectations.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_imem_boot_ctrl;

  localparam int WORDS = 256;
`ifdef IMEM_BOOT_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  word_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, imem_we, core_rst, busy, done, err;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;

  int total = 0;
  int bad   = 0;

  imem_boot_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit          m_busy, m_done_now, m_ck_got, m_err;
  int          m_cnt, m_nbytes, m_nwr;
  logic [31:0] m_word;
  logic [7:0]  m_sum;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  int          wr_count = 0;
  int          first_addr = -1;
  int          last_addr = -1;

  initial begin
    m_busy = 0; m_done_now = 0; m_ck_got = 0; m_err = 0;
    m_cnt = 0; m_nbytes = 0; m_nwr = 0; m_word = '0; m_sum = '0;
    m_addr = '0; m_data = '0;
  end

  // Inputs change 1ns after the rising edge, so at the falling edge they hold
  // exactly the values the next rising edge will sample.
  always @(negedge clk) begin : cmp
    bit e_we, e_ready;
    if (rst) begin
      m_busy = 0; m_done_now = 0; m_err = 0; m_ck_got = 0;
      m_addr = '0; m_data = '0;
      check("rst_ready", byte_ready, 0);
      check("rst_we", imem_we, 0);
      check("rst_waddr", imem_waddr, 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_core_rst", core_rst, 1);
    end else begin
      // A full word's worth of bytes that has not been written yet means
      // this is the write cycle.
      e_we    = m_busy && !m_done_now && (m_nbytes == 4 * (m_nwr + 1));
      e_ready = m_busy && !m_done_now && !e_we &&
                ((m_nwr < m_cnt) || (CK && !m_ck_got));
      if (e_we) begin
        m_addr = 8'(m_nwr);
        m_data = m_word;
      end
      check("we", imem_we, e_we);
      check("ready", byte_ready, e_ready);
      check("waddr", imem_waddr, m_addr);
      check("wdata", imem_wdata, m_data);
      check("busy", busy, m_busy);
      check("done", done, m_done_now);
      check("err", err, m_err);
      check("core_rst", core_rst, m_busy);

      if (imem_we) begin
        wr_count++;
        last_addr = imem_waddr;
        if (first_addr < 0) first_addr = imem_waddr;
      end

      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_nbytes = 0; m_nwr = 0; m_sum = '0; m_err = 0;
          m_ck_got = 0; m_word = '0;
          m_cnt = (int'(word_count) > WORDS) ? WORDS : int'(word_count);
          m_done_now = (m_cnt == 0);
        end
      end else if (m_done_now) begin
        m_busy = 0; m_done_now = 0;
      end else if (e_we) begin
        m_nwr++;
        if (m_nwr == m_cnt && !CK) m_done_now = 1;
      end else if (e_ready && byte_valid) begin
        if (m_nwr < m_cnt) begin
          m_word[8 * (m_nbytes % 4) +: 8] = byte_data;
          m_sum += byte_data;
          m_nbytes++;
        end else begin
          m_err = (byte_data != m_sum);
          m_ck_got = 1;
          m_done_now = 1;
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit x;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 64; k++) begin
      x = byte_ready;
      tick();
      if (x) begin
        byte_valid = 1'b0;
        return;
      end
    end
    byte_valid = 1'b0;
    check("byte_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20000; k++) begin
      if (!busy) return;
      tick();
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_load(input int wc, input bit gaps, input bit spur);
    int n;
    logic [7:0] s, b;
    word_count = 9'(wc); start = 1'b1; tick();
    start = 1'b0; word_count = '0;
    n = ((wc > WORDS) ? WORDS : wc) * 4;
    s = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin byte_valid = 1'b0; tick(); end
      b = 8'($urandom);
      s += b;
      send_byte(b);
      if (spur && i == 0) begin
        start = 1'b1; word_count = 9'd5; tick();
        start = 1'b0; word_count = '0;
      end
    end
    if (CK && n > 0) send_byte(s);
    wait_idle();
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) tick();
    check("reset_core_rst", core_rst, 1);
    check("reset_waddr", imem_waddr, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // One word: 13 00 00 00 -> write 0x00000013 at address 0.
    word_count = 9'd1; start = 1'b1; tick();
    start = 1'b0;
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("w1_we", imem_we, 1);
    check("w1_waddr", imem_waddr, 0);
    check("w1_wdata", imem_wdata, 32'h0000_0013);
    if (CK) send_byte(8'h13);
    else tick();
    check("w1_done", done, 1);
    tick();
    check("w1_core_rst_released", core_rst, 0);
    check("w1_idle", busy, 0);

    // Three words with byte_valid toggling.
    wr_count = 0; first_addr = -1;
    run_load(3, 1'b1, 1'b0);
    check("w3_writes", wr_count, 3);
    check("w3_first", first_addr, 0);
    check("w3_last", last_addr, 2);

    // Count clamped to the memory depth.
    wr_count = 0; first_addr = -1;
    run_load(300, 1'b0, 1'b0);
    check("w300_writes", wr_count, 256);
    check("w300_first", first_addr, 0);
    check("w300_last", last_addr, 255);

    // Zero words: done the cycle after start, no write.
    wr_count = 0;
    word_count = 9'd0; start = 1'b1; tick();
    start = 1'b0;
    check("w0_done", done, 1);
    check("w0_we", imem_we, 0);
    tick();
    check("w0_idle", busy, 0);
    check("w0_writes", wr_count, 0);

    // Spurious start during RECV is ignored.
    wr_count = 0;
    run_load(2, 1'b0, 1'b1);
    check("spur_writes", wr_count, 2);

    // Reset after 2 of 4 words, then a fresh load restarts at address 0.
    word_count = 9'd4; start = 1'b1; tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_we", imem_we, 0);
    check("abort_waddr", imem_waddr, 0);
    check("abort_wdata", imem_wdata, 0);
    check("abort_ready", byte_ready, 0);
    check("abort_core_rst", core_rst, 1);
    tick();
    rst = 1'b0;
    tick();
    wr_count = 0; first_addr = -1;
    run_load(1, 1'b0, 1'b0);
    check("restart_first", first_addr, 0);
    check("restart_writes", wr_count, 1);

`ifdef IMEM_BOOT_CKSUM_EN
    // 01+02+03+04 = 0x0A.
    word_count = 9'd1; start = 1'b1; tick();
    start = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0A);
    wait_idle();
    check("ck_good_err", err, 0);
    word_count = 9'd1; start = 1'b1; tick();
    start = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0B);
    wait_idle();
    repeat (3) tick();
    check("ck_bad_err_sticky", err, 1);
    word_count = 9'd0; start = 1'b1; tick();
    start = 1'b0;
    check("ck_err_cleared", err, 0);
    wait_idle();
`endif

    // Randomized traffic: starts, counts, stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom % 400 == 0);
      start      = ($urandom % 25 == 0);
      word_count = ($urandom % 10 == 0) ? 9'($urandom_range(250, 511))
                                        : 9'($urandom % 6);
      byte_valid = ($urandom % 4 != 0);
      byte_data  = 8'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imem_boot_ctrl
`default_nettype wire

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, 256, instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, 8, word-address width (log2 IMEM_WORDS).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port word_count  input  ADDR_W+1  number of words to load; latched on accepted start.
REQ-007 SHALL have port byte_valid  input  1  loader byte stream valid.
REQ-008 SHALL have port byte_data  input  8  loader byte stream data.
REQ-009 SHALL have port byte_ready  output  1  block accepts a byte this cycle.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_waddr  output  ADDR_W  instruction-memory word address.
REQ-012 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-013 SHALL have port core_rst  output  1  holds the core in reset while loading.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on load completion.
REQ-016 SHALL have port err  output  1  sticky checksum-mismatch flag.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE, CHECK, DONE.
REQ-018 SHALL in IDLE on start=1 latch min(word_count, IMEM_WORDS), clear word index, byte lane, checksum and err, then go to RECV; if the latched count is 0, go directly to DONE.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL drive byte_ready=1 only in RECV and CHECK; a byte transfers when byte_valid & byte_ready.
REQ-021 SHALL assemble bytes little-endian: byte lane 0 -> imem_wdata[7:0], lane 3 -> [31:24]; the lane counter wraps 3->0.
REQ-022 SHALL go RECV->WRITE on the cycle after the lane-3 transfer; WRITE lasts exactly one cycle with imem_we=1, imem_waddr=word index, imem_wdata=assembled word.
REQ-023 SHALL increment the word index in WRITE; if the new index equals the latched count, go to CHECK (macro on) or DONE (macro off), else back to RECV.
REQ-024 SHALL hold imem_we=0 in all states except WRITE; imem_waddr/imem_wdata hold their last values otherwise.
REQ-025 SHALL drive core_rst=1 in RECV, WRITE, CHECK and DONE, and 0 in IDLE.
REQ-026 SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE.
REQ-027 SHALL give latency: lane-3 byte accepted in cycle N -> imem_we in N+1 -> done in N+2 for the last word (macro off).
REQ-028 SHALL never wrap the word index past IMEM_WORDS-1, because counts are clamped.

Reset
REQ-029 SHALL on rst=1 immediately force IDLE with byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, err=0, and core_rst=1 while rst is high.
REQ-030 SHALL, if reset occurs mid-load, abort the load without restoring instruction-memory contents already written.

Configuration
REQ-031 SHALL compile checksum support under macro IMEM_BOOT_CKSUM_EN.
REQ-032 SHALL, with IMEM_BOOT_CKSUM_EN defined, accumulate an 8-bit modulo-256 sum of all data bytes.
REQ-033 SHALL, with IMEM_BOOT_CKSUM_EN defined, accept one trailing byte in CHECK, compare it to the sum, set err=1 on mismatch, then go to DONE.
REQ-034 SHALL, with IMEM_BOOT_CKSUM_EN defined, skip CHECK when count=0.
REQ-035 SHALL, without IMEM_BOOT_CKSUM_EN, remove CHECK and the checksum logic and tie err to 0.

Structure
REQ-036 SHALL place the FSM state enum, IMEM_WORDS default and ADDR_W default in shared package imem_boot_pkg.
REQ-037 SHALL implement byte-to-word assembly (lane counter plus 32-bit shift register) as sub-module imem_byte_packer.

Verification
REQ-038 SHALL cover: start with word_count=1, bytes 13,00,00,00 -> one imem_we with waddr=0, wdata=32'h00000013, then done one cycle later, then core_rst=0.
REQ-039 SHALL cover: word_count=3 with byte_valid toggling every other cycle -> three writes to addresses 0,1,2, no write while byte_valid=0.
REQ-040 SHALL cover: word_count=300 -> exactly 256 writes to addresses 0..255, then done.
REQ-041 SHALL cover: word_count=0 -> done on the cycle after start with no imem_we; a start pulse during RECV is ignored.
REQ-042 SHALL cover: rst asserted after 2 of 4 words -> outputs at reset values immediately, and a new load restarts at address 0.
REQ-043 SHALL cover (macro on): bytes 01,02,03,04 then checksum 0A -> err=0; with checksum 0B -> err=1 held until the next start.
